// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register word offsets
// (addr[4:2]) and trigger-mode encodings.
package irq_ctrl_pkg;

  localparam logic [2:0] IRQ_REG_PENDING   = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE    = 3'd1;
  localparam logic [2:0] IRQ_REG_TRIGGER   = 3'd2;
  localparam logic [2:0] IRQ_REG_CLAIM     = 3'd3;
  localparam logic [2:0] IRQ_REG_COMPLETE  = 3'd4;
  localparam logic [2:0] IRQ_REG_INSERVICE = 3'd5;

  localparam logic IRQ_TRIG_LEVEL = 1'b0;
  localparam logic IRQ_TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line, plus a
// history flop so the caller gets both the level and a rising-edge strobe.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Metastability chain followed by the previous-cycle copy of the clean level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped external interrupt controller. Latches synchronised lines
// as edge/level pending bits, tracks claimed (in-service) sources and
// raises a registered request to the CPU for any claimable source.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEI_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEI_PORTS-1:0] irq,
  input  logic                 sel,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [3:0]           wenable,
  output logic [XLEN-1:0]      rdata,
  output logic                 mei_pending
);

  logic [MEI_PORTS-1:0] level;
  logic [MEI_PORTS-1:0] rise;
  logic [MEI_PORTS-1:0] pending;
  logic [MEI_PORTS-1:0] enable;
  logic [MEI_PORTS-1:0] trigger;
  logic [MEI_PORTS-1:0] in_service;
  logic [MEI_PORTS-1:0] pending_next;
  logic [MEI_PORTS-1:0] enable_next;
  logic [MEI_PORTS-1:0] trigger_next;
  logic [MEI_PORTS-1:0] in_service_next;
  logic [MEI_PORTS-1:0] claimable;
  logic [MEI_PORTS-1:0] claim_hit;
  logic [MEI_PORTS-1:0] complete_hit;

  logic [2:0] reg_sel;
  logic [4:0] wid;
  logic       claim_wr;
  logic       complete_wr;
  logic       enable_wr;
  logic       trigger_wr;
  logic       unused_bits;

  assign reg_sel     = addr[4:2];
  assign wid         = wdata[4:0];
  assign claim_wr    = sel && wenable[0] && (reg_sel == IRQ_REG_CLAIM);
  assign complete_wr = sel && wenable[0] && (reg_sel == IRQ_REG_COMPLETE);
  assign enable_wr   = sel && (reg_sel == IRQ_REG_ENABLE);
  assign trigger_wr  = sel && (reg_sel == IRQ_REG_TRIGGER);
  assign claimable   = pending & enable & ~in_service;

  // Address bits outside [4:2] and write lanes beyond the source count carry no meaning
  assign unused_bits = ^{addr[XLEN-1:5], addr[1:0], wdata, wenable};

  // Lowest-index claimable source wins; ID is index+1, 0 means none
  function automatic logic [4:0] first_id(input logic [MEI_PORTS-1:0] v);
    logic [4:0] id;
    id = 5'd0;
    for (int i = MEI_PORTS - 1; i >= 0; i--) begin
      if (v[i]) id = 5'(i + 1);
    end
    return id;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < MEI_PORTS; gi++) begin : g_src
      irq_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .irq   (irq[gi]),
        .level (level[gi]),
        .rise  (rise[gi])
      );

      // ID compare against gi+1 rejects k=0 and k>MEI_PORTS by construction
      assign claim_hit[gi]    = claim_wr && (wid == 5'(gi + 1)) && claimable[gi];
      assign complete_hit[gi] = complete_wr && (wid == 5'(gi + 1)) && in_service[gi];

      // Edge: a new edge beats a same-cycle claim. Level: mirror the line.
      assign pending_next[gi] = (trigger[gi] == IRQ_TRIG_EDGE)
                              ? (rise[gi] | (pending[gi] & ~claim_hit[gi]))
                              : level[gi];

      assign in_service_next[gi] = complete_hit[gi] ? 1'b0
                                 : claim_hit[gi]    ? 1'b1
                                 : in_service[gi];

      assign enable_next[gi]  = (enable_wr && wenable[gi / 8])  ? wdata[gi] : enable[gi];
      assign trigger_next[gi] = (trigger_wr && wenable[gi / 8]) ? wdata[gi] : trigger[gi];
    end
  endgenerate

  // Controller state and the registered CPU request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= '0;
      enable      <= '0;
      trigger     <= '0;
      in_service  <= '0;
      mei_pending <= 1'b0;
    end else begin
      pending     <= pending_next;
      enable      <= enable_next;
      trigger     <= trigger_next;
      in_service  <= in_service_next;
      mei_pending <= |claimable;
    end
  end

  // Side-effect-free combinational register read
  always_comb begin
    rdata = '0;
    case (reg_sel)
      IRQ_REG_PENDING:   rdata[MEI_PORTS-1:0] = pending;
      IRQ_REG_ENABLE:    rdata[MEI_PORTS-1:0] = enable;
      IRQ_REG_TRIGGER:   rdata[MEI_PORTS-1:0] = trigger;
      IRQ_REG_CLAIM:     rdata[4:0]           = first_id(claimable);
      IRQ_REG_INSERVICE: rdata[MEI_PORTS-1:0] = in_service;
      default:           rdata                = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each task drives one scenario and checks
// hand-computed register values and request timing.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq = '0;
  logic        sel = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wenable = '0;
  logic [31:0] rdata;
  logic        mei_pending;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] R_PEND = 3'd0, R_EN = 3'd1, R_TRIG = 3'd2, R_CLAIM = 3'd3,
                         R_COMP = 3'd4, R_INS = 3'd5;

  irq_ctrl #(.XLEN(32), .MEI_PORTS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .sel         (sel),
    .addr        (addr),
    .wdata       (wdata),
    .wenable     (wenable),
    .rdata       (rdata),
    .mei_pending (mei_pending)
  );

  always #5 clk = ~clk;

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    @(negedge clk);
    addr = {27'd0, off, 2'b00};
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    sel = 1'b1; addr = {27'd0, off, 2'b00}; wdata = d; wenable = we;
    @(posedge clk);
    #1;
    sel = 1'b0; wenable = 4'b0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    irq = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    total++; if (mei_pending !== 1'b0) $display("FAIL reset_mei got %b want 0", mei_pending); else passed++;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      total++; if (d !== 32'h0) $display("FAIL reset_read off=%0d got %h want 0", i, d); else passed++;
    end
  endtask

  task automatic test_edge_claim();
    logic [31:0] d;
    do_reset();
    wr(R_EN, 32'h1, 4'b0001);
    wr(R_TRIG, 32'h1, 4'b0001);
    @(negedge clk); irq[0] = 1'b1;
    @(posedge clk); #1; irq[0] = 1'b0;          // E0 captured
    wait_edges(2);                               // E1, E2: pending set
    total++; if (mei_pending !== 1'b0) $display("FAIL edge_mei_e2 got %b want 0", mei_pending); else passed++;
    wait_edges(1);                               // E3
    total++; if (mei_pending !== 1'b1) $display("FAIL edge_mei_e3 got %b want 1", mei_pending); else passed++;
    rd(R_PEND, d);
    total++; if (d !== 32'h1) $display("FAIL edge_pending got %h want 1", d); else passed++;
    rd(R_CLAIM, d);
    total++; if (d !== 32'h1) $display("FAIL edge_claim_rd got %h want 1", d); else passed++;
    wr(R_CLAIM, 32'h1, 4'b0001);
    total++; if (mei_pending !== 1'b1) $display("FAIL claim_mei_w got %b want 1", mei_pending); else passed++;
    wait_edges(1);
    total++; if (mei_pending !== 1'b0) $display("FAIL claim_mei_w1 got %b want 0", mei_pending); else passed++;
    rd(R_PEND, d);
    total++; if (d !== 32'h0) $display("FAIL claim_pending got %h want 0", d); else passed++;
    rd(R_INS, d);
    total++; if (d !== 32'h1) $display("FAIL claim_inservice got %h want 1", d); else passed++;
  endtask

  task automatic test_level_priority();
    logic [31:0] d;
    do_reset();
    wr(R_EN, 32'hF, 4'b0001);
    @(negedge clk); irq = 4'b1010;
    wait_edges(4);
    rd(R_CLAIM, d);
    total++; if (d !== 32'h2) $display("FAIL level_claim1 got %h want 2", d); else passed++;
    wr(R_CLAIM, 32'h2, 4'b0001);
    rd(R_CLAIM, d);
    total++; if (d !== 32'h4) $display("FAIL level_claim2 got %h want 4", d); else passed++;
    rd(R_PEND, d);
    total++; if (d !== 32'hA) $display("FAIL level_pending_kept got %h want a", d); else passed++;
    wr(R_COMP, 32'h2, 4'b0001);
    rd(R_CLAIM, d);
    total++; if (d !== 32'h2) $display("FAIL level_claim3 got %h want 2", d); else passed++;
    rd(R_INS, d);
    total++; if (d !== 32'h0) $display("FAIL level_inservice got %h want 0", d); else passed++;
  endtask

  task automatic test_queued_edge();
    logic [31:0] d;
    do_reset();
    wr(R_EN, 32'h1, 4'b0001);
    wr(R_TRIG, 32'h1, 4'b0001);
    @(negedge clk); irq[0] = 1'b1;
    @(posedge clk); #1; irq[0] = 1'b0;
    wait_edges(3);
    wr(R_CLAIM, 32'h1, 4'b0001);
    @(negedge clk); irq[0] = 1'b1;
    @(posedge clk); #1; irq[0] = 1'b0;
    wait_edges(4);
    rd(R_PEND, d);
    total++; if (d !== 32'h1) $display("FAIL queued_pending got %h want 1", d); else passed++;
    rd(R_CLAIM, d);
    total++; if (d !== 32'h0) $display("FAIL queued_claim got %h want 0", d); else passed++;
    total++; if (mei_pending !== 1'b0) $display("FAIL queued_mei got %b want 0", mei_pending); else passed++;
    wr(R_COMP, 32'h1, 4'b0001);
    total++; if (mei_pending !== 1'b0) $display("FAIL complete_mei_w got %b want 0", mei_pending); else passed++;
    wait_edges(1);
    total++; if (mei_pending !== 1'b1) $display("FAIL complete_mei_w1 got %b want 1", mei_pending); else passed++;
    rd(R_CLAIM, d);
    total++; if (d !== 32'h1) $display("FAIL complete_claim got %h want 1", d); else passed++;
  endtask

  task automatic test_invalid();
    logic [31:0] d;
    do_reset();
    wr(R_EN, 32'h1, 4'b0001);
    wr(R_TRIG, 32'h1, 4'b0001);
    @(negedge clk); irq[0] = 1'b1;
    @(posedge clk); #1; irq[0] = 1'b0;
    wait_edges(3);
    wr(R_CLAIM, 32'h0, 4'b0001);
    wr(R_CLAIM, 32'h7, 4'b0001);
    wr(R_COMP, 32'h3, 4'b0001);
    wr(R_CLAIM, 32'h1, 4'b0010);
    wr(R_PEND, 32'h0, 4'b1111);
    rd(R_INS, d);
    total++; if (d !== 32'h0) $display("FAIL invalid_inservice got %h want 0", d); else passed++;
    rd(R_PEND, d);
    total++; if (d !== 32'h1) $display("FAIL invalid_pending got %h want 1", d); else passed++;
    total++; if (mei_pending !== 1'b1) $display("FAIL invalid_mei got %b want 1", mei_pending); else passed++;
    wr(R_EN, 32'hFF, 4'b0010);
    rd(R_EN, d);
    total++; if (d !== 32'h1) $display("FAIL lane1_enable got %h want 1", d); else passed++;
    wr(R_EN, 32'hFF, 4'b0001);
    rd(R_EN, d);
    total++; if (d !== 32'hF) $display("FAIL lane0_enable got %h want f", d); else passed++;
    rd(R_TRIG, d);
    total++; if (d !== 32'h1) $display("FAIL trigger_kept got %h want 1", d); else passed++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    @(negedge clk); irq = 4'b0111;
    wr(R_EN, 32'h7, 4'b0001);
    wait_edges(3);
    wr(R_CLAIM, 32'h1, 4'b0001);
    wr(R_CLAIM, 32'h2, 4'b0001);
    rd(R_INS, d);
    total++; if (d !== 32'h3) $display("FAIL pre_rst_inservice got %h want 3", d); else passed++;
    wait_edges(1);
    total++; if (mei_pending !== 1'b1) $display("FAIL pre_rst_mei got %b want 1", mei_pending); else passed++;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (mei_pending !== 1'b0) $display("FAIL async_mei got %b want 0", mei_pending); else passed++;
    addr = {27'd0, R_INS, 2'b00}; #1;
    total++; if (rdata !== 32'h0) $display("FAIL async_inservice got %h want 0", rdata); else passed++;
    addr = {27'd0, R_PEND, 2'b00}; #1;
    total++; if (rdata !== 32'h0) $display("FAIL async_pending got %h want 0", rdata); else passed++;
    addr = {27'd0, R_EN, 2'b00}; #1;
    total++; if (rdata !== 32'h0) $display("FAIL async_enable got %h want 0", rdata); else passed++;
    @(negedge clk);
    irq = '0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_claim();
    test_level_priority();
    test_queued_edge();
    test_invalid();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
